wave_player: RTL

WAVE_PLAYER -- requirements
Module: wave_player

---
 rtl/wave_pkg.sv | 23 ++
 rtl/tick_div.sv | 38 +++
 rtl/wave_player.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/wave_pkg.sv
// Shared widths, idle sample level and FSM state encoding for the wave player.
// Imported by the player top and its divider.
package wave_pkg;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 8;

    // Mid-scale level for unsigned audio, shown while nothing has been played.
    localparam logic [DATA_W-1:0] SAMPLE_IDLE = 8'h80;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StWait  = 2'd2,
        StHold  = 2'd3
    } state_e;

    // ROM addresses wrap modulo 2**ADDR_W.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/tick_div.sv
// Sample-rate divider: counts 0..DIV-1 while enabled and flags the last count.
// clr has priority over en so a new play always starts from count 0.
module tick_div #(
    parameter int unsigned DIV = 24
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;

    assign tick = (count_q == CntMax);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tick ? '0 : count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wave_player.sv
// Plays a span of an 8-bit sample ROM at one sample every DIV clocks,
// optionally looping, with abort via stop.
module wave_player
    import wave_pkg::*;
#(
    parameter int unsigned DIV      = 24,
    parameter bit          LOOP_DEF = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] rom_a,
    output logic              rom_cs_n,
    input  logic [DATA_W-1:0] rom_dout,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              busy,
    output logic              done
);

    state_e state_q;
    state_e state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] start_q;
    logic [ADDR_W-1:0] start_d;
    logic [ADDR_W-1:0] end_q;
    logic [ADDR_W-1:0] end_d;
    logic              loop_q;
    logic              loop_d;
    logic [DATA_W-1:0] sample_q;
    logic [DATA_W-1:0] sample_d;
    logic              sample_valid_q;
    logic              sample_valid_d;
    logic              done_q;
    logic              done_d;

    logic div_clr;
    logic tick;

    tick_div #(
        .DIV(DIV)
    ) u_tick_div (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (div_clr),
        .en     (busy),
        .tick   (tick)
    );

    assign busy         = (state_q != StIdle);
    assign rom_cs_n     = (state_q != StFetch);
    assign rom_a        = addr_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign done         = done_q;

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        start_d        = start_q;
        end_d          = end_q;
        loop_d         = loop_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        done_d         = 1'b0;
        div_clr        = 1'b0;

        // stop outranks everything, including a read whose data is arriving now.
        if (stop) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        start_d = start_addr;
                        end_d   = end_addr;
                        loop_d  = loop;
                        addr_d  = start_addr;
                        div_clr = 1'b1;
                        state_d = StFetch;
                    end
                end
                StFetch: begin
                    state_d = StWait;
                end
                StWait: begin
                    sample_d       = rom_dout;
                    sample_valid_d = 1'b1;
                    state_d        = StHold;
                end
                StHold: begin
                    if (tick) begin
                        if (addr_q != end_q) begin
                            addr_d  = addr_inc(addr_q);
                            state_d = StFetch;
                        end else if (loop_q) begin
                            addr_d  = start_q;
                            state_d = StFetch;
                        end else begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            addr_q         <= '0;
            start_q        <= '0;
            end_q          <= '0;
            loop_q         <= LOOP_DEF;
            sample_q       <= SAMPLE_IDLE;
            sample_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            start_q        <= start_d;
            end_q          <= end_d;
            loop_q         <= loop_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            done_q         <= done_d;
        end
    end

endmodule
